rgb_stream_frame_arbiter: RTL and testbench

Frame-granular two-input AXI4-Stream arbiter that shares a single RGB-to-grayscale conversion core between two video sources. It grants the downstream stream to one source for exactly one whole frame, bounded by the `tuser` start-of-frame beat and the LINES-th `tlast`. It then re-arbitrates round-robin. Beats arriving on a source before its start-of-frame are flushed, so the core only ever sees frame-aligned video.

---
 rtl/rgb_stream_frame_arbiter.sv | 84 ++++++++
 tb/tb_rgb_stream_frame_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_stream_frame_arbiter.sv
// rgb_stream_frame_arbiter: frame-granular round-robin AXI4-Stream arbiter feeding one grayscale core
// Ports:
//   aclk, aresetn              clock, asynchronous active-low reset
//   s0_axis_*, s1_axis_*       source streams (tuser = start-of-frame)
//   m_axis_*                   granted stream toward the grayscale core
//   grant                      one-hot active source {s1,s0}, 0 while arbitrating
//   frame_done, sof_err        one-cycle pulses: frame completed / unexpected SOF mid-frame
module rgb_stream_frame_arbiter #(
    parameter int DATA_W = 24,
    parameter int LINES  = 480,
    parameter int CNT_W  = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s0_axis_tvalid,
    output logic              s0_axis_tready,
    input  logic              s0_axis_tlast,
    input  logic              s0_axis_tuser,
    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic              s1_axis_tvalid,
    output logic              s1_axis_tready,
    input  logic              s1_axis_tlast,
    input  logic              s1_axis_tuser,
    input  logic [DATA_W-1:0] s1_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [1:0]        grant,
    output logic              frame_done,
    output logic              sof_err
);
    typedef enum logic [1:0] {ARB, BUSY0, BUSY1} state_t;
    localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(LINES - 1);
    state_t           state, state_nx;
    logic [CNT_W-1:0] line_cnt, line_cnt_nx, eff_cnt;
    logic             last_src, last_src_nx, first_beat, first_beat_nx;
    logic             req0, req1, busy, sel1, acc, mid_sof, frame_end;
    assign req0 = s0_axis_tvalid & s0_axis_tuser;
    assign req1 = s1_axis_tvalid & s1_axis_tuser;
    assign busy = state != ARB;
    assign sel1 = state == BUSY1;
    assign grant = {state == BUSY1, state == BUSY0};
    assign m_axis_tvalid = busy & (sel1 ? s1_axis_tvalid : s0_axis_tvalid);
    assign m_axis_tlast  = busy & (sel1 ? s1_axis_tlast : s0_axis_tlast);
    assign m_axis_tuser  = busy & (sel1 ? s1_axis_tuser : s0_axis_tuser);
    assign m_axis_tdata  = busy ? (sel1 ? s1_axis_tdata : s0_axis_tdata) : '0;
    // In ARB non-SOF beats are flushed and SOF beats are held for the grant.
    assign s0_axis_tready = state == BUSY0 ? m_axis_tready : state == ARB & s0_axis_tvalid & ~s0_axis_tuser;
    assign s1_axis_tready = state == BUSY1 ? m_axis_tready : state == ARB & s1_axis_tvalid & ~s1_axis_tuser;
    assign acc = m_axis_tvalid & m_axis_tready;
    assign mid_sof = acc & m_axis_tuser & ~first_beat;
    // A mid-frame SOF restarts the count before its own tlast is considered.
    assign eff_cnt = mid_sof ? '0 : line_cnt;
    assign frame_end = acc & m_axis_tlast & (eff_cnt == LAST_LINE);
    always_comb begin
        state_nx = state;
        if (state == ARB)
            state_nx = req0 & req1 ? (last_src ? BUSY0 : BUSY1) : req0 ? BUSY0 : req1 ? BUSY1 : ARB;
        else if (frame_end)
            state_nx = ARB;
        line_cnt_nx   = frame_end ? '0 : acc & m_axis_tlast ? eff_cnt + CNT_W'(1) : eff_cnt;
        last_src_nx   = frame_end ? sel1 : last_src;
        first_beat_nx = (state == ARB) | (first_beat & ~acc);
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ARB;
            line_cnt   <= '0;
            last_src   <= 1'b1;
            first_beat <= 1'b0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            line_cnt   <= line_cnt_nx;
            last_src   <= last_src_nx;
            first_beat <= first_beat_nx;
            frame_done <= frame_end;
            sof_err    <= mid_sof;
        end
    end
endmodule

// File: tb/tb_rgb_stream_frame_arbiter.sv
// tb_rgb_stream_frame_arbiter: directed bench for rgb_stream_frame_arbiter (instances with LINES=2,3,1)
module tb_rgb_stream_frame_arbiter;
    typedef logic [25:0] beat_t;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;
    logic        s0_tvalid = 1'b0, s0_tlast = 1'b0, s0_tuser = 1'b0;
    logic        s1_tvalid = 1'b0, s1_tlast = 1'b0, s1_tuser = 1'b0;
    logic [23:0] s0_tdata = '0, s1_tdata = '0;
    logic        m_tready = 1'b1;
    logic [2:0]  s0_tready, s1_tready, m_tvalid, m_tlast, m_tuser, frame_done, sof_err;
    logic [23:0] m_tdata [3];
    logic [1:0]  grant [3];
    int   sel = 0, cyc = 0, total = 0, bad = 0, se_n = 0, stall_n = 0;
    bit   bp = 1'b0;
    beat_t q0[$], q1[$], exp[$], outq[$];
    logic [1:0] expg[$], outg[$];
    int   outc[$], fd_c[$];

    genvar g;
    for (g = 0; g < 3; g++) begin : g_dut
        rgb_stream_frame_arbiter #(.DATA_W(24), .LINES(g == 0 ? 2 : g == 1 ? 3 : 1), .CNT_W(16)) u_dut (
            .aclk(aclk), .aresetn(aresetn),
            .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready[g]), .s0_axis_tlast(s0_tlast),
            .s0_axis_tuser(s0_tuser), .s0_axis_tdata(s0_tdata),
            .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready[g]), .s1_axis_tlast(s1_tlast),
            .s1_axis_tuser(s1_tuser), .s1_axis_tdata(s1_tdata),
            .m_axis_tvalid(m_tvalid[g]), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast[g]),
            .m_axis_tuser(m_tuser[g]), .m_axis_tdata(m_tdata[g]),
            .grant(grant[g]), .frame_done(frame_done[g]), .sof_err(sof_err[g])
        );
    end

    // Sources drive on the falling edge; handshakes are sampled 1 ns before the rising edge.
    always begin
        @(negedge aclk);
        s0_tvalid = q0.size() != 0;
        if (q0.size() != 0) {s0_tuser, s0_tlast, s0_tdata} = q0[0];
        else {s0_tuser, s0_tlast, s0_tdata} = '0;
        s1_tvalid = q1.size() != 0;
        if (q1.size() != 0) {s1_tuser, s1_tlast, s1_tdata} = q1[0];
        else {s1_tuser, s1_tlast, s1_tdata} = '0;
        m_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        #4;
        cyc++;
        if (s0_tvalid && s0_tready[sel] && q0.size() != 0) void'(q0.pop_front());
        if (s1_tvalid && s1_tready[sel] && q1.size() != 0) void'(q1.pop_front());
        if (m_tvalid[sel] && m_tready) begin
            outq.push_back({m_tuser[sel], m_tlast[sel], m_tdata[sel]});
            outg.push_back(grant[sel]);
            outc.push_back(cyc);
        end
        if (frame_done[sel]) fd_c.push_back(cyc);
        if (sof_err[sel]) se_n++;
        if (grant[sel] == 2'b01 && s1_tready[sel]) stall_n++;
    end

    task automatic pb(input int src, input bit u, input bit l, input int d, input bit e);
        beat_t b;
        b = {u, l, 24'(d)};
        if (src == 0) q0.push_back(b); else q1.push_back(b);
        if (e) begin
            exp.push_back(b);
            expg.push_back(src == 0 ? 2'b01 : 2'b10);
        end
    endtask

    task automatic add(input int src, input int lines, input int ppl, input int base, input bit e);
        for (int l = 0; l < lines; l++)
            for (int p = 0; p < ppl; p++)
                pb(src, l == 0 && p == 0, p == ppl - 1, base + l * ppl + p, e);
    endtask

    task automatic clear_rec;
        outq.delete(); outg.delete(); outc.delete(); fd_c.delete();
        se_n = 0; stall_n = 0;
    endtask

    task automatic do_reset(input int s);
        @(posedge aclk); #2;
        aresetn = 1'b0; sel = s; bp = 1'b0;
        q0.delete(); q1.delete(); exp.delete(); expg.delete();
        repeat (2) @(posedge aclk);
        #2;
        aresetn = 1'b1;
        clear_rec();
    endtask

    task automatic wait_drain(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(posedge aclk); #2;
            if (q0.size() == 0 && q1.size() == 0 && grant[sel] == 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge aclk);
        #2;
    endtask

    task automatic test_reset;
        @(posedge aclk); #2;
        aresetn = 1'b0; sel = 0;
        q0.delete(); q1.delete();
        repeat (2) @(posedge aclk);
        #2;
        total++; if (m_tvalid[0] !== 1'b0) begin bad++; $display("FAIL rst_tvalid got %b exp 0", m_tvalid[0]); end
        total++; if (m_tdata[0] !== 24'h0) begin bad++; $display("FAIL rst_tdata got %h exp 0", m_tdata[0]); end
        total++; if ({m_tlast[0], m_tuser[0]} !== 2'b00) begin bad++; $display("FAIL rst_tlast_tuser got %b exp 00", {m_tlast[0], m_tuser[0]}); end
        total++; if (grant[0] !== 2'b00) begin bad++; $display("FAIL rst_grant got %b exp 00", grant[0]); end
        total++; if ({frame_done[0], sof_err[0]} !== 2'b00) begin bad++; $display("FAIL rst_pulses got %b exp 00", {frame_done[0], sof_err[0]}); end
        total++; if ({s1_tready[0], s0_tready[0]} !== 2'b00) begin bad++; $display("FAIL rst_tready got %b exp 00", {s1_tready[0], s0_tready[0]}); end
        aresetn = 1'b1;
    endtask

    task automatic test_round_robin;
        bit ok;
        int c0;
        do_reset(0);
        c0 = cyc;
        add(0, 2, 4, 'h100, 1); add(1, 2, 4, 'h200, 1);
        add(0, 2, 4, 'h300, 1); add(1, 2, 4, 'h400, 1);
        wait_drain(400, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rr_drain got %b exp 1", ok); end
        total++; if (outq.size() !== 32) begin bad++; $display("FAIL rr_count got %0d exp 32", outq.size()); end
        total++; if (fd_c.size() !== 4) begin bad++; $display("FAIL rr_frame_done got %0d exp 4", fd_c.size()); end
        for (int i = 0; i < 32 && i < outq.size(); i++) begin
            total++;
            if (outq[i] !== exp[i] || outg[i] !== expg[i]) begin
                bad++; $display("FAIL rr_beat%0d got %h/%b exp %h/%b", i, outq[i], outg[i], exp[i], expg[i]);
            end
        end
        total++; if ((outc.size() > 0 ? outc[0] : -1) !== c0 + 2) begin bad++; $display("FAIL rr_first_latency got %0d exp %0d", outc.size() > 0 ? outc[0] : -1, c0 + 2); end
        if (outc.size() >= 9 && fd_c.size() >= 1) begin
            total++; if (outc[8] - outc[7] !== 2) begin bad++; $display("FAIL rr_dead_time got %0d exp 2", outc[8] - outc[7]); end
            total++; if (fd_c[0] !== outc[7] + 1) begin bad++; $display("FAIL rr_fd_timing got %0d exp %0d", fd_c[0], outc[7] + 1); end
        end
    endtask

    task automatic test_junk_flush;
        bit ok;
        do_reset(0);
        for (int i = 0; i < 5; i++) pb(1, 1'b0, i == 3, 'h50 + i, 1'b0);
        add(1, 2, 2, 'h600, 1);
        wait_drain(200, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL junk_drain got %b exp 1", ok); end
        total++; if (outq.size() !== 4) begin bad++; $display("FAIL junk_count got %0d exp 4", outq.size()); end
        total++; if ((outq.size() > 0 ? outq[0] : '0) !== {2'b10, 24'h600}) begin bad++; $display("FAIL junk_first_beat got %h exp %h", outq.size() > 0 ? outq[0] : '0, {2'b10, 24'h600}); end
        total++; if ((outg.size() > 0 ? outg[0] : 2'b00) !== 2'b10) begin bad++; $display("FAIL junk_grant got %b exp 10", outg.size() > 0 ? outg[0] : 2'b00); end
        total++; if (fd_c.size() !== 1) begin bad++; $display("FAIL junk_frame_done got %0d exp 1", fd_c.size()); end
    endtask

    task automatic test_backpressure;
        bit ok;
        do_reset(0);
        bp = 1'b1;
        add(0, 2, 4, 'h700, 1); add(1, 2, 4, 'h800, 1);
        wait_drain(800, ok);
        bp = 1'b0;
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_drain got %b exp 1", ok); end
        total++; if (outq.size() !== 16) begin bad++; $display("FAIL bp_count got %0d exp 16", outq.size()); end
        for (int i = 0; i < 16 && i < outq.size(); i++) begin
            total++;
            if (outq[i] !== exp[i] || outg[i] !== expg[i]) begin
                bad++; $display("FAIL bp_beat%0d got %h/%b exp %h/%b", i, outq[i], outg[i], exp[i], expg[i]);
            end
        end
        total++; if (stall_n !== 0) begin bad++; $display("FAIL bp_s1_stall got %0d ready cycles exp 0", stall_n); end
    endtask

    task automatic test_mid_sof;
        bit ok;
        do_reset(1);
        pb(0, 1, 0, 1, 1); pb(0, 0, 1, 2, 1); pb(0, 1, 0, 3, 1); pb(0, 0, 1, 4, 1);
        pb(0, 0, 0, 5, 1); pb(0, 0, 1, 6, 1); pb(0, 0, 0, 7, 1); pb(0, 0, 1, 8, 1);
        wait_drain(200, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL mid_drain got %b exp 1", ok); end
        total++; if (se_n !== 1) begin bad++; $display("FAIL mid_sof_err got %0d exp 1", se_n); end
        total++; if (outq.size() !== 8) begin bad++; $display("FAIL mid_count got %0d exp 8", outq.size()); end
        total++; if (fd_c.size() !== 1) begin bad++; $display("FAIL mid_frame_done got %0d exp 1", fd_c.size()); end
        if (fd_c.size() == 1 && outc.size() == 8) begin
            total++; if (fd_c[0] !== outc[7] + 1) begin bad++; $display("FAIL mid_fd_timing got %0d exp %0d", fd_c[0], outc[7] + 1); end
        end
        clear_rec(); exp.delete(); expg.delete();
        pb(0, 1, 0, 9, 1); pb(0, 0, 1, 10, 1); pb(0, 1, 1, 11, 1);
        pb(0, 0, 1, 12, 1); pb(0, 0, 0, 13, 1); pb(0, 0, 1, 14, 1);
        wait_drain(200, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL mid2_drain got %b exp 1", ok); end
        total++; if (se_n !== 1) begin bad++; $display("FAIL mid2_sof_err got %0d exp 1", se_n); end
        total++; if (outq.size() !== 6) begin bad++; $display("FAIL mid2_count got %0d exp 6", outq.size()); end
        if (fd_c.size() == 1 && outc.size() == 6) begin
            total++; if (fd_c[0] !== outc[5] + 1) begin bad++; $display("FAIL mid2_fd_timing got %0d exp %0d", fd_c[0], outc[5] + 1); end
        end else begin
            total++; bad++; $display("FAIL mid2_frame_done got %0d pulses exp 1", fd_c.size());
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        do_reset(0);
        add(0, 2, 4, 'h900, 0); add(1, 2, 4, 'hA00, 1);
        for (int i = 0; i < 200 && outq.size() < 6; i++) @(posedge aclk);
        @(posedge aclk); #2;
        total++; if (outq.size() < 6 || outq.size() > 7) begin bad++; $display("FAIL rm_progress got %0d beats exp 6..7", outq.size()); end
        aresetn = 1'b0;
        #1;
        total++; if (m_tvalid[0] !== 1'b0 || m_tdata[0] !== 24'h0) begin bad++; $display("FAIL rm_out got %b/%h exp 0/0", m_tvalid[0], m_tdata[0]); end
        total++; if (grant[0] !== 2'b00) begin bad++; $display("FAIL rm_grant got %b exp 00", grant[0]); end
        total++; if ({s1_tready[0], s0_tready[0]} !== 2'b01) begin bad++; $display("FAIL rm_tready got %b exp 01", {s1_tready[0], s0_tready[0]}); end
        repeat (2) @(posedge aclk);
        #2;
        clear_rec();
        aresetn = 1'b1;
        wait_drain(200, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rm_drain got %b exp 1", ok); end
        total++; if (outq.size() !== 8) begin bad++; $display("FAIL rm_count got %0d exp 8", outq.size()); end
        for (int i = 0; i < 8 && i < outq.size(); i++) begin
            total++;
            if (outq[i] !== exp[i] || outg[i] !== expg[i]) begin
                bad++; $display("FAIL rm_beat%0d got %h/%b exp %h/%b", i, outq[i], outg[i], exp[i], expg[i]);
            end
        end
    endtask

    task automatic test_lines1;
        bit ok;
        do_reset(2);
        add(0, 1, 3, 'h10, 1); add(1, 1, 3, 'h20, 1);
        add(0, 1, 3, 'h30, 1); add(1, 1, 3, 'h40, 1);
        wait_drain(200, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL l1_drain got %b exp 1", ok); end
        total++; if (outq.size() !== 12) begin bad++; $display("FAIL l1_count got %0d exp 12", outq.size()); end
        total++; if (fd_c.size() !== 4) begin bad++; $display("FAIL l1_frame_done got %0d exp 4", fd_c.size()); end
        for (int i = 0; i < 12 && i < outq.size(); i++) begin
            total++;
            if (outq[i] !== exp[i] || outg[i] !== expg[i]) begin
                bad++; $display("FAIL l1_beat%0d got %h/%b exp %h/%b", i, outq[i], outg[i], exp[i], expg[i]);
            end
        end
        if (fd_c.size() >= 1 && outc.size() >= 3) begin
            total++; if (fd_c[0] !== outc[2] + 1) begin bad++; $display("FAIL l1_fd_timing got %0d exp %0d", fd_c[0], outc[2] + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_junk_flush();
        test_backpressure();
        test_mid_sof();
        test_reset_mid();
        test_lines1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
